gpio_seg7_ctrl: RTL and testbench

Parametrised seven-segment display controller driven by the processor GPIO write port (`we_gpio` / `gpio_o`) on the DE2-115 platform. It latches each GPIO write, decodes every 4-bit nibble to a 7-segment hex glyph, and drives the segments two ways. The first is a registered static bus, one glyph per digit. The second is a time-multiplexed digit-scan bus for boards with shared segment lines. It adds leading-zero suppression, a per-digit blank mask, and a blink mode.

---
 rtl/gpio_seg7_ctrl_pkg.sv | 39 +++
 rtl/gpio_seg7_ctrl_if.sv | 11 +
 rtl/gpio_seg7_ctrl_scan.sv | 75 +++++++
 rtl/gpio_seg7_ctrl.sv | 110 +++++++++++
 tb/tb_gpio_seg7_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/gpio_seg7_ctrl_pkg.sv
// Shared types, constants and the hex-to-glyph decoder for the seven-segment controller.
// Glyphs are active-low with bit order g..a.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_ZERO  = 7'h40;

    typedef enum logic {
        SHOW = 1'b0,
        DEAD = 1'b1
    } scan_state_e;

    function automatic seg7_t hex2seg(input logic [3:0] nib);
        seg7_t seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0011000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/gpio_seg7_ctrl_if.sv
// GPIO write port as seen by the display controller: write strobe, data word and update acknowledge.
interface gpio_seg7_ctrl_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  we_gpio;
    logic [DATA_WIDTH-1:0] gpio_o;
    logic                  upd_ack;

    modport master (output we_gpio, output gpio_o, input upd_ack);
    modport slave  (input we_gpio, input gpio_o, output upd_ack);
endinterface

// File: rtl/gpio_seg7_ctrl_scan.sv
// Digit-scan engine: SHOW for SCAN_DIV-1 cycles, then one DEAD cycle with all digits off while idx advances.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7*NUM_DIGITS-1:0] seg_static,
    output seg7_t                   seg_mux,
    output logic [NUM_DIGITS-1:0]   dig_sel_n
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    seg7_t                   seg_mux_r;
    logic [NUM_DIGITS-1:0]   dig_sel_n_r;
    logic [IDX_W-1:0]        idx_next_s;

    function automatic logic [NUM_DIGITS-1:0] sel_n(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

    assign idx_next_s = (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);

    // Scan FSM; outputs are registered from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SHOW;
            cnt_r       <= {CNT_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            seg_mux_r   <= SEG_ZERO;
            dig_sel_n_r <= ~NUM_DIGITS'(1);
        end else begin
            case (state_r)
                SHOW: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r     <= DEAD;
                        cnt_r       <= {CNT_W{1'b0}};
                        seg_mux_r   <= SEG_BLANK;
                        dig_sel_n_r <= {NUM_DIGITS{1'b1}};
                    end else begin
                        cnt_r       <= cnt_r + CNT_W'(1);
                        seg_mux_r   <= seg_static[7*idx_r +: 7];
                        dig_sel_n_r <= sel_n(idx_r);
                    end
                end
                DEAD: begin
                    state_r     <= SHOW;
                    idx_r       <= idx_next_s;
                    seg_mux_r   <= seg_static[7*idx_next_s +: 7];
                    dig_sel_n_r <= sel_n(idx_next_s);
                end
                default: begin
                    state_r     <= SHOW;
                    cnt_r       <= {CNT_W{1'b0}};
                    idx_r       <= {IDX_W{1'b0}};
                    seg_mux_r   <= SEG_ZERO;
                    dig_sel_n_r <= ~NUM_DIGITS'(1);
                end
            endcase
        end
    end

    assign seg_mux   = seg_mux_r;
    assign dig_sel_n = dig_sel_n_r;

endmodule

// File: rtl/gpio_seg7_ctrl.sv
// Seven-segment controller: latches GPIO writes, decodes nibbles with mask/suppression/blink blanking,
// and drives both a static per-digit bus and a multiplexed scan bus.
module gpio_seg7_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_WIDTH = 32,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 2**22
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gpio_seg7_ctrl_if.slave         bus,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    input  logic                    blink_en,
    output logic [7*NUM_DIGITS-1:0] seg_static,
    output seg7_t                   seg_mux,
    output logic [NUM_DIGITS-1:0]   dig_sel_n
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [DATA_WIDTH-1:0]   gpio_word_s;
    logic [VAL_W-1:0]        value_r;
    logic                    ack_pend_r;
    logic                    upd_ack_r;
    logic [BLK_W-1:0]        blink_cnt_r;
    logic                    blink_off_r;
    logic [IDX_W-1:0]        msd_s;
    logic [NUM_DIGITS-1:0]   blank_s;
    logic [7*NUM_DIGITS-1:0] glyph_s;
    logic [7*NUM_DIGITS-1:0] seg_static_r;

    assign gpio_word_s = bus.gpio_o;

    // Value register and the two-stage acknowledge that lines up with the static bus update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r    <= {VAL_W{1'b0}};
            ack_pend_r <= 1'b0;
            upd_ack_r  <= 1'b0;
        end else begin
            if (bus.we_gpio) begin
                value_r <= gpio_word_s[VAL_W-1:0];
            end
            ack_pend_r <= bus.we_gpio;
            upd_ack_r  <= ack_pend_r;
        end
    end

    // Blink phase generator; held at the start of an ON half-period while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= {BLK_W{1'b0}};
            blink_off_r <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt_r <= {BLK_W{1'b0}};
            blink_off_r <= 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= {BLK_W{1'b0}};
            blink_off_r <= ~blink_off_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLK_W'(1);
        end
    end

    // Decode with blanking; msd_s stays 0 for a zero value so digit 0 is never suppressed.
    always_comb begin
        msd_s   = {IDX_W{1'b0}};
        blank_s = {NUM_DIGITS{1'b0}};
        glyph_s = {NUM_DIGITS{SEG_BLANK}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            msd_s = (value_r[4*i +: 4] != 4'h0) ? IDX_W'(i) : msd_s;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            blank_s[i] = blank_mask[i]
                       | (lz_suppress & (IDX_W'(i) > msd_s))
                       | (blink_en & blink_off_r);
            glyph_s[7*i +: 7] = blank_s[i] ? SEG_BLANK : hex2seg(value_r[4*i +: 4]);
        end
    end

    // Static segment bus register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_static_r <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            seg_static_r <= glyph_s;
        end
    end

    assign seg_static  = seg_static_r;
    assign bus.upd_ack = upd_ack_r;

    seg7_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_static (seg_static_r),
        .seg_mux    (seg_mux),
        .dig_sel_n  (dig_sel_n)
    );

endmodule

// File: tb/tb_gpio_seg7_ctrl.sv
// Directed bench for gpio_seg7_ctrl: static decode table, write/ack timing, scan sequence, blink/mask, async reset.
module tb_gpio_seg7_ctrl;

    localparam int ND   = 8;
    localparam int DW   = 32;
    localparam int SCAN = 4;
    localparam int BLK  = 3;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0011000, GA = 7'b0001000, GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110, GF = 7'b0001110;
    localparam logic [6:0] GBL = 7'b1111111;

    localparam logic [31:0] OLDV = 32'h0123ABCD;
    localparam logic [31:0] NEWV = 32'h0123A7CD;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ND-1:0]   blank_mask;
    logic            lz_suppress;
    logic            blink_en;
    logic [7*ND-1:0] seg_static;
    logic [6:0]      seg_mux;
    logic [ND-1:0]   dig_sel_n;

    int checks = 0;
    int errors = 0;

    gpio_seg7_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    gpio_seg7_ctrl #(
        .NUM_DIGITS (ND),
        .DATA_WIDTH (DW),
        .SCAN_DIV   (SCAN),
        .BLINK_DIV  (BLK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .blink_en    (blink_en),
        .seg_static  (seg_static),
        .seg_mux     (seg_mux),
        .dig_sel_n   (dig_sel_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     value;
        logic [ND-1:0]   mask;
        logic            lz;
        logic [7*ND-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return G0;  4'h1: return G1;  4'h2: return G2;  4'h3: return G3;
            4'h4: return G4;  4'h5: return G5;  4'h6: return G6;  4'h7: return G7;
            4'h8: return G8;  4'h9: return G9;  4'hA: return GA;  4'hB: return GB;
            4'hC: return GC;  4'hD: return GD;  4'hE: return GE;  4'hF: return GF;
            default: return GBL;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] v);
        bus.we_gpio = 1'b1;
        bus.gpio_o  = v;
        tick();
        bus.we_gpio = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_static"}, 64'(seg_static), 64'({ND{G0}}));
        check({tag, "_mux"},    64'(seg_mux),    64'(G0));
        check({tag, "_dsel"},   64'(dig_sel_n),  64'(8'hFE));
        check({tag, "_ack"},    64'(bus.upd_ack), 64'(1'b0));
    endtask

    initial begin
        logic [31:0] exp_val;
        logic [6:0]  exp_mux;
        logic [7:0]  exp_dsel;
        int          phase;
        int          d;

        vecs[0] = '{32'h0123ABCD, 8'h00, 1'b0, {G0, G1, G2, G3, GA, GB, GC, GD}};
        vecs[1] = '{32'h000000F0, 8'h00, 1'b1, {GBL, GBL, GBL, GBL, GBL, GBL, GF, G0}};
        vecs[2] = '{32'h00000000, 8'h00, 1'b1, {GBL, GBL, GBL, GBL, GBL, GBL, GBL, G0}};
        vecs[3] = '{32'h0123ABCD, 8'h00, 1'b1, {GBL, G1, G2, G3, GA, GB, GC, GD}};
        vecs[4] = '{32'h89ABCDEF, 8'h81, 1'b0, {GBL, G9, GA, GB, GC, GD, GE, GBL}};
        vecs[5] = '{32'h00000000, 8'h00, 1'b0, {G0, G0, G0, G0, G0, G0, G0, G0}};
        vecs[6] = '{32'h45670000, 8'h00, 1'b1, {G4, G5, G6, G7, G0, G0, G0, G0}};
        vecs[7] = '{32'h00100000, 8'h01, 1'b1, {GBL, GBL, G1, G0, G0, G0, G0, GBL}};

        // Reset with non-default control inputs: outputs must still show reset values.
        rst_n       = 1'b0;
        blank_mask  = 8'hFF;
        lz_suppress = 1'b1;
        blink_en    = 1'b1;
        bus.we_gpio = 1'b0;
        bus.gpio_o  = 32'h0;
        tick();
        tick();
        check_reset_values("reset");
        blank_mask  = 8'h00;
        lz_suppress = 1'b0;
        blink_en    = 1'b0;
        rst_n       = 1'b1;
        tick();

        // Table: write, static bus one edge later, single ack pulse.
        for (int v = 0; v < 8; v++) begin
            blank_mask  = vecs[v].mask;
            lz_suppress = vecs[v].lz;
            write(vecs[v].value);
            check($sformatf("ack_pre_%0d", v), 64'(bus.upd_ack), 64'(1'b0));
            tick();
            check($sformatf("static_%0d", v), 64'(seg_static), 64'(vecs[v].exp));
            check($sformatf("ack_%0d", v), 64'(bus.upd_ack), 64'(1'b1));
            tick();
            check($sformatf("ack_post_%0d", v), 64'(bus.upd_ack), 64'(1'b0));
        end

        // Back-to-back writes: two ack pulses, last value wins.
        blank_mask  = 8'h00;
        lz_suppress = 1'b0;
        bus.we_gpio = 1'b1;
        bus.gpio_o  = 32'h11111111;
        tick();
        bus.gpio_o  = 32'h22222222;
        tick();
        bus.we_gpio = 1'b0;
        check("b2b_ack1", 64'(bus.upd_ack), 64'(1'b1));
        check("b2b_static1", 64'(seg_static), 64'({ND{G1}}));
        tick();
        check("b2b_ack2", 64'(bus.upd_ack), 64'(1'b1));
        check("b2b_static2", 64'(seg_static), 64'({ND{G2}}));
        tick();
        check("b2b_ack3", 64'(bus.upd_ack), 64'(1'b0));

        // Scan: fresh reset so edge k after release sits at slot k/4, phase k%4 (phase 3 is DEAD).
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 63; k++) begin
            tick();
            phase    = k % SCAN;
            d        = (k / SCAN) % ND;
            exp_dsel = (phase == SCAN - 1) ? 8'hFF : ~(8'b1 << d);
            check($sformatf("scan_dsel_k%0d", k), 64'(dig_sel_n), 64'(exp_dsel));
            if (k >= 4) begin
                exp_val = (k >= 42) ? NEWV : OLDV;
                exp_mux = (phase == SCAN - 1) ? GBL : glyph(exp_val[d*4 +: 4]);
                check($sformatf("scan_mux_k%0d", k), 64'(seg_mux), 64'(exp_mux));
            end
            if (k == 41) begin
                check("midslot_static_d2", 64'(seg_static[2*7 +: 7]), 64'(G7));
            end
            if (k == 1 || k == 39) begin
                bus.we_gpio = 1'b1;
                bus.gpio_o  = (k == 1) ? OLDV : NEWV;
            end else begin
                bus.we_gpio = 1'b0;
            end
        end

        // Asynchronous reset during the DEAD cycle after edge 63.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("dead_reset");
        tick();
        rst_n = 1'b1;

        // Blink with digits 0 and 7 masked: 3 cycles glyph, 3 cycles blank.
        blank_mask = 8'h81;
        write(OLDV);
        tick();
        tick();
        tick();
        blink_en = 1'b1;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (((j / BLK) % 2) == 0) begin
                check($sformatf("blink_on_%0d", j), 64'(seg_static),
                      64'({GBL, G1, G2, G3, GA, GB, GC, GBL}));
            end else begin
                check($sformatf("blink_off_%0d", j), 64'(seg_static), 64'({ND{GBL}}));
            end
        end
        blink_en = 1'b0;
        tick();
        check("blink_disabled", 64'(seg_static), 64'({GBL, G1, G2, G3, GA, GB, GC, GBL}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
